tsp_search_ctrl: RTL and testbench
==================================

// Module: tsp_search_ctrl
// PURPOSE
//  Sequences one TSP search job: loads key words into key_buffer, pulses start,
//  waits for the match count, then drains the result FIFO to a host stream.
//  Sits between the host/command logic and tsp_top's BUFFER_*/IRDEN/ODATA ports.
//  Jobs run one at a time; a watchdog aborts any wait phase that stalls.
// PARAMETERS
//  KEY_MAX      256    max key words per job (KEY_LEN range 1..KEY_MAX)
//  TIMEOUT_CYC  2**20  cycles allowed in WAIT_CNT or waiting on one ODATAVALID
//  RES_DEPTH    8      result skid FIFO depth (power of 2)
// PORTS
//  ICLK           in   1   clock
//  IRESET         in   1   synchronous active-high reset
//  CMD_VALID      in   1   job request
//  CMD_READY      out  1   high only in IDLE
//  CMD_BYTEMODE   in   2   byte mode, latched at CMD accept
//  CMD_KEYLEN     in   9   key words in this job, latched at CMD accept
//  KEY_VALID      in   1   key word valid
//  KEY_READY      out  1   high only in LOAD
//  KEY_DATA       in   14  key word {flags, byte}
//  BUFFER_START   out  1   1-cycle start pulse to key_buffer
//  BUFFER_BYTEMODE out 2   latched byte mode
//  BUFFER_IKEY    out  14  key word to key_buffer
//  BUFFER_WREN    out  1   key write strobe
//  ICONTINUE      out  1   1-cycle key_buffer rewind pulse at end of job
//  MATCH_COUNT    in   32  total matches from core
//  MATCH_COUNT_VALID in 1  MATCH_COUNT qualifier
//  IRDEN          out  1   result read strobe
//  ODATA          in   16  result offset
//  ODATAVALID     in   1   ODATA qualifier, any latency >=1 after IRDEN
//  RES_VALID      out  1   host result valid
//  RES_READY      in   1   host result accept
//  RES_DATA       out  16  host result
//  RES_LAST       out  1   marks final result of the job
//  BUSY           out  1   state != IDLE
//  DONE           out  1   1-cycle pulse when the job completes or aborts
//  TIMEOUT_ERR    out  1   sticky; cleared on next CMD accept
//  MATCHES        out  32  latched MATCH_COUNT of last job
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except CMD_READY=1; FIFO emptied;
//   counters 0. Reset mid-job abandons the job with no DONE pulse.
//  IDLE->LOAD on CMD_VALID&&CMD_READY. Latch mode and len (len 0 -> treated 1).
//  LOAD: BUFFER_WREN=KEY_VALID&&KEY_READY, BUFFER_IKEY=KEY_DATA same cycle
//   (combinational). Word counter counts accepts; on the len-th accept -> START.
//  START: BUFFER_START=1 exactly one cycle -> WAIT_CNT, watchdog cleared.
//  WAIT_CNT: on MATCH_COUNT_VALID latch MATCHES. If 0 -> FINISH, else -> DRAIN.
//   Watchdog reaching TIMEOUT_CYC -> TIMEOUT_ERR=1, go to FINISH.
//  DRAIN: at most one read outstanding. IRDEN=1 for one cycle when !outstanding,
//   issued<MATCHES and FIFO count+outstanding<RES_DEPTH. Each ODATAVALID pushes
//   ODATA into FIFO and clears outstanding. ODATAVALID with nothing outstanding
//   is ignored. Watchdog counts while outstanding; expiry -> TIMEOUT_ERR, FINISH.
//   When received==MATCHES and FIFO empty -> FINISH.
//  Result side: FIFO head on RES_DATA; RES_VALID=!fifo_empty; pop on
//   RES_VALID&&RES_READY. RES_LAST=1 on the entry whose receive index==MATCHES.
//   Same-cycle push+pop on a full FIFO is legal (count unchanged).
//  FINISH: ICONTINUE=1 and DONE=1 for one cycle; discard any FIFO content
//   (abort only) -> IDLE. Received/issued counters are 32-bit, no wrap.
// STRUCTURE
//  Package tsp_ctrl_pkg: state enum (IDLE,LOAD,START,WAIT_CNT,DRAIN,FINISH),
//   KEY_W=14, RES_W=16, CNT_W=32.
//  Sub-module tsp_result_fifo: synchronous FIFO, RES_DEPTH x 16 plus last bit,
//   count output, synchronous reset. Everything else in one FSM module.
// TESTING
//  Reset with CMD_VALID=1 -> CMD_READY=1, BUSY=0, all strobes 0 after reset.
//  Job len=3, mode=2, keys 0x101,0x102,0x103 -> 3 WREN with those words,
//   BUFFER_BYTEMODE=2, one START pulse the cycle after 3rd accept.
//  MATCH_COUNT=0 valid -> DONE+ICONTINUE pulse, no IRDEN, RES_VALID never 1.
//  MATCH_COUNT=20, ODATA latency 3, RES_READY toggling 50% -> 20 results in
//   order, RES_LAST only on 20th, never >1 read outstanding, FIFO never overflows.
//  MATCH_COUNT_VALID never arrives, TIMEOUT_CYC=64 -> TIMEOUT_ERR=1 and DONE
//   at cycle 64 of WAIT_CNT; next CMD accept clears TIMEOUT_ERR.
//  IRESET asserted mid-DRAIN -> next cycle IDLE, RES_VALID=0, no DONE pulse.

Source files
------------

// File: rtl/tsp_ctrl_pkg.sv
// Shared types and widths for the TSP search job controller.
//   KEY_W  : key word width {flags, byte}
//   RES_W  : result offset width
//   CNT_W  : match / read counter width
//   state_t and St* : controller FSM encoding
package tsp_ctrl_pkg;

  localparam int unsigned KEY_W = 14;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StLoad    = 3'd1;
  localparam state_t StStart   = 3'd2;
  localparam state_t StWaitCnt = 3'd3;
  localparam state_t StDrain   = 3'd4;
  localparam state_t StFinish  = 3'd5;

endpackage

// File: rtl/tsp_result_fifo.sv
// Result skid FIFO: Depth entries of {last, data}, synchronous reset and flush.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : empty the FIFO (takes priority over push/pop)
//   push_i, wdata_i, wlast_i : write side
//   pop_i            : read side, head shown on rdata_o/rlast_o
//   empty_o, count_o : occupancy
// Push while full is accepted only together with a pop (count unchanged).
module tsp_result_fifo
  import tsp_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [RES_W-1:0] wdata_i,
  input  logic             wlast_i,
  input  logic             pop_i,
  output logic [RES_W-1:0] rdata_o,
  output logic             rlast_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [RES_W:0]  mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= {wlast_i, wdata_i};
  end

  assign rdata_o = mem_q[rptr_q][RES_W-1:0];
  assign rlast_o = mem_q[rptr_q][RES_W];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/tsp_search_ctrl.sv
// Sequences one TSP search job: key load -> start -> wait match count -> drain results.
//   Command  : CMD_VALID/READY, CMD_BYTEMODE, CMD_KEYLEN (latched on accept)
//   Keys     : KEY_VALID/READY/DATA passed straight to BUFFER_WREN/BUFFER_IKEY
//   key_buffer: BUFFER_START, BUFFER_BYTEMODE, ICONTINUE
//   Core     : MATCH_COUNT(_VALID), IRDEN, ODATA(VALID)
//   Host     : RES_VALID/READY/DATA/LAST
//   Status   : BUSY, DONE (1-cycle), TIMEOUT_ERR (sticky), MATCHES
module tsp_search_ctrl
  import tsp_ctrl_pkg::*;
#(
  parameter int unsigned KEY_MAX     = 256,
  parameter int unsigned TIMEOUT_CYC = 2**20,
  parameter int unsigned RES_DEPTH   = 8
) (
  input  logic             ICLK,
  input  logic             IRESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_BYTEMODE,
  input  logic [8:0]       CMD_KEYLEN,
  input  logic             KEY_VALID,
  output logic             KEY_READY,
  input  logic [KEY_W-1:0] KEY_DATA,
  output logic             BUFFER_START,
  output logic [1:0]       BUFFER_BYTEMODE,
  output logic [KEY_W-1:0] BUFFER_IKEY,
  output logic             BUFFER_WREN,
  output logic             ICONTINUE,
  input  logic [CNT_W-1:0] MATCH_COUNT,
  input  logic             MATCH_COUNT_VALID,
  output logic             IRDEN,
  input  logic [RES_W-1:0] ODATA,
  input  logic             ODATAVALID,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [RES_W-1:0] RES_DATA,
  output logic             RES_LAST,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] MATCHES
);

  localparam int unsigned     FCntW   = $clog2(RES_DEPTH + 1);
  localparam int unsigned     WdW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FCntW-1:0] FifoCap = FCntW'(RES_DEPTH);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [8:0]       keylen_q, keylen_d;
  logic [8:0]       key_cnt_q, key_cnt_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0] matches_q, matches_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] received_q, received_d;
  logic             outstanding_q, outstanding_d;
  logic             timeout_q, timeout_d;

  logic             rd_issue, rd_return;
  logic             fifo_empty, fifo_last;
  logic [RES_W-1:0] fifo_data;
  logic [FCntW-1:0] fifo_count;

  // With no read outstanding, "count + outstanding < depth" reduces to count < depth.
  assign rd_issue  = (state_q == StDrain) && !outstanding_q && (issued_q < matches_q) &&
                     (fifo_count < FifoCap);
  assign rd_return = outstanding_q && ODATAVALID;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    keylen_d      = keylen_q;
    key_cnt_d     = key_cnt_q;
    wd_d          = wd_q;
    matches_d     = matches_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    timeout_d     = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          mode_d    = CMD_BYTEMODE;
          key_cnt_d = '0;
          timeout_d = 1'b0;
          if (CMD_KEYLEN == '0)                  keylen_d = 9'd1;
          else if (32'(CMD_KEYLEN) > KEY_MAX)    keylen_d = 9'(KEY_MAX);
          else                                   keylen_d = CMD_KEYLEN;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (KEY_VALID) begin
          key_cnt_d = key_cnt_q + 9'd1;
          if (key_cnt_q + 9'd1 == keylen_q) state_d = StStart;
        end
      end
      StStart: begin
        wd_d          = '0;
        issued_d      = '0;
        received_d    = '0;
        outstanding_d = 1'b0;
        state_d       = StWaitCnt;
      end
      StWaitCnt: begin
        if (MATCH_COUNT_VALID) begin
          matches_d = MATCH_COUNT;
          state_d   = (MATCH_COUNT == '0) ? StFinish : StDrain;
        end else if (wd_q == WdLast) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDrain: begin
        if ((received_q == matches_q) && fifo_empty) begin
          state_d = StFinish;
        end else if (rd_issue) begin
          outstanding_d = 1'b1;
          issued_d      = issued_q + 1'b1;
          wd_d          = '0;
        end else if (rd_return) begin
          outstanding_d = 1'b0;
          received_d    = received_q + 1'b1;
        end else if (outstanding_q) begin
          if (wd_q == WdLast) begin
            timeout_d = 1'b1;
            state_d   = StFinish;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      StFinish: begin
        outstanding_d = 1'b0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ICLK) begin
    if (IRESET) begin
      state_q       <= StIdle;
      mode_q        <= '0;
      keylen_q      <= '0;
      key_cnt_q     <= '0;
      wd_q          <= '0;
      matches_q     <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      keylen_q      <= keylen_d;
      key_cnt_q     <= key_cnt_d;
      wd_q          <= wd_d;
      matches_q     <= matches_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      timeout_q     <= timeout_d;
    end
  end

  // FINISH flushes leftovers from an aborted drain; a clean finish already has it empty.
  tsp_result_fifo #(
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (ICLK),
    .rst_i   (IRESET),
    .flush_i (state_q == StFinish),
    .push_i  (rd_return),
    .wdata_i (ODATA),
    .wlast_i (received_q + 1'b1 == matches_q),
    .pop_i   (RES_VALID && RES_READY),
    .rdata_o (fifo_data),
    .rlast_o (fifo_last),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign CMD_READY       = (state_q == StIdle);
  assign KEY_READY       = (state_q == StLoad);
  assign BUFFER_WREN     = KEY_READY && KEY_VALID;
  assign BUFFER_IKEY     = BUFFER_WREN ? KEY_DATA : '0;
  assign BUFFER_START    = (state_q == StStart);
  assign BUFFER_BYTEMODE = mode_q;
  assign ICONTINUE       = (state_q == StFinish);
  assign DONE            = (state_q == StFinish);
  assign BUSY            = (state_q != StIdle);
  assign IRDEN           = rd_issue;
  assign RES_VALID       = !fifo_empty;
  assign RES_DATA        = RES_VALID ? fifo_data : '0;
  assign RES_LAST        = RES_VALID && fifo_last;
  assign TIMEOUT_ERR     = timeout_q;
  assign MATCHES         = matches_q;

endmodule

// File: tb/tb_tsp_search_ctrl.sv
// Directed bench for tsp_search_ctrl (TIMEOUT_CYC=64, RES_DEPTH=8).
module tb_tsp_search_ctrl;

  logic        ICLK;
  logic        IRESET;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_BYTEMODE;
  logic [8:0]  CMD_KEYLEN;
  logic        KEY_VALID, KEY_READY;
  logic [13:0] KEY_DATA;
  logic        BUFFER_START;
  logic [1:0]  BUFFER_BYTEMODE;
  logic [13:0] BUFFER_IKEY;
  logic        BUFFER_WREN, ICONTINUE;
  logic [31:0] MATCH_COUNT;
  logic        MATCH_COUNT_VALID;
  logic        IRDEN;
  logic [15:0] ODATA;
  logic        ODATAVALID;
  logic        RES_VALID, RES_READY;
  logic [15:0] RES_DATA;
  logic        RES_LAST, BUSY, DONE, TIMEOUT_ERR;
  logic [31:0] MATCHES;

  int n_cmp = 0;
  int n_err = 0;
  int rd_idx = 0;
  int reads_total = 0;
  logic resp_en = 1'b0;

  tsp_search_ctrl #(
    .KEY_MAX     (256),
    .TIMEOUT_CYC (64),
    .RES_DEPTH   (8)
  ) dut (
    .ICLK              (ICLK),
    .IRESET            (IRESET),
    .CMD_VALID         (CMD_VALID),
    .CMD_READY         (CMD_READY),
    .CMD_BYTEMODE      (CMD_BYTEMODE),
    .CMD_KEYLEN        (CMD_KEYLEN),
    .KEY_VALID         (KEY_VALID),
    .KEY_READY         (KEY_READY),
    .KEY_DATA          (KEY_DATA),
    .BUFFER_START      (BUFFER_START),
    .BUFFER_BYTEMODE   (BUFFER_BYTEMODE),
    .BUFFER_IKEY       (BUFFER_IKEY),
    .BUFFER_WREN       (BUFFER_WREN),
    .ICONTINUE         (ICONTINUE),
    .MATCH_COUNT       (MATCH_COUNT),
    .MATCH_COUNT_VALID (MATCH_COUNT_VALID),
    .IRDEN             (IRDEN),
    .ODATA             (ODATA),
    .ODATAVALID        (ODATAVALID),
    .RES_VALID         (RES_VALID),
    .RES_READY         (RES_READY),
    .RES_DATA          (RES_DATA),
    .RES_LAST          (RES_LAST),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .TIMEOUT_ERR       (TIMEOUT_ERR),
    .MATCHES           (MATCHES)
  );

  initial ICLK = 1'b0;
  always #5 ICLK = ~ICLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: each accepted IRDEN returns ODATA=0xA000+index three edges later.
  // Also tracks reads in flight as seen on the pins.
  initial begin : responder
    int due[$];
    int cyc;
    int out_cnt;
    cyc = 0;
    out_cnt = 0;
    ODATAVALID = 1'b0;
    ODATA = '0;
    forever begin
      @(posedge ICLK);
      cyc++;
      #1;
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        ODATAVALID = 1'b1;
        ODATA = 16'hA000 + 16'(rd_idx);
        rd_idx++;
      end else begin
        ODATAVALID = 1'b0;
      end
      @(negedge ICLK);
      if (ODATAVALID) out_cnt--;
      if (IRDEN && resp_en) begin
        check("reads_in_flight", 32'(out_cnt), 32'd0);
        out_cnt++;
        reads_total++;
        due.push_back(cyc + 3);
      end
    end
  end

  task automatic start_job(input logic [1:0] mode, input logic [8:0] len);
    @(posedge ICLK); #1;
    CMD_BYTEMODE = mode;
    CMD_KEYLEN = len;
    CMD_VALID = 1'b1;
    @(negedge ICLK);
    check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    @(posedge ICLK); #1;
    CMD_VALID = 1'b0;
  endtask

  // Returns at the negedge of the first WAIT_CNT cycle.
  task automatic load_keys(input int n, input logic [13:0] base);
    for (int i = 0; i < n; i++) begin
      KEY_VALID = 1'b1;
      KEY_DATA = base + 14'(i);
      @(negedge ICLK);
      check("key_ready", 32'(KEY_READY), 32'd1);
      check("wren", 32'(BUFFER_WREN), 32'd1);
      check("ikey", 32'(BUFFER_IKEY), 32'(base + 14'(i)));
      check("start_early", 32'(BUFFER_START), 32'd0);
      @(posedge ICLK); #1;
    end
    KEY_VALID = 1'b0;
    @(negedge ICLK);
    check("start_pulse", 32'(BUFFER_START), 32'd1);
    check("wren_after_load", 32'(BUFFER_WREN), 32'd0);
    @(posedge ICLK); #1;
    @(negedge ICLK);
    check("start_one_cycle", 32'(BUFFER_START), 32'd0);
  endtask

  initial begin : global_bound
    #100000;
    $display("FAIL global_time_limit: bench still running");
    $fatal(1);
  end

  initial begin : main
    int pops;
    int wc;
    int done_cnt;
    logic got_res;
    logic done_seen;
    logic seen_valid;

    IRESET = 1'b1;
    CMD_VALID = 1'b1;
    CMD_BYTEMODE = 2'd0;
    CMD_KEYLEN = 9'd0;
    KEY_VALID = 1'b0;
    KEY_DATA = '0;
    MATCH_COUNT = '0;
    MATCH_COUNT_VALID = 1'b0;
    RES_READY = 1'b0;

    // Reset with CMD_VALID held high
    repeat (3) @(posedge ICLK);
    @(negedge ICLK);
    check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_key_ready", 32'(KEY_READY), 32'd0);
    check("rst_start", 32'(BUFFER_START), 32'd0);
    check("rst_irden", 32'(IRDEN), 32'd0);
    check("rst_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_timeout", 32'(TIMEOUT_ERR), 32'd0);
    @(posedge ICLK); #1;
    CMD_VALID = 1'b0;
    IRESET = 1'b0;

    // Job 1: len 3, mode 2, zero matches
    start_job(2'd2, 9'd3);
    check("j1_busy", 32'(BUSY), 32'd1);
    load_keys(3, 14'h101);
    check("j1_bytemode", 32'(BUFFER_BYTEMODE), 32'd2);
    @(posedge ICLK); #1;
    MATCH_COUNT = 32'd0;
    MATCH_COUNT_VALID = 1'b1;
    @(posedge ICLK); #1;
    MATCH_COUNT_VALID = 1'b0;
    @(negedge ICLK);
    check("j1_done", 32'(DONE), 32'd1);
    check("j1_icontinue", 32'(ICONTINUE), 32'd1);
    check("j1_res_valid", 32'(RES_VALID), 32'd0);
    @(posedge ICLK); #1;
    @(negedge ICLK);
    check("j1_done_pulse", 32'(DONE), 32'd0);
    check("j1_idle", 32'(BUSY), 32'd0);
    check("j1_no_reads", 32'(reads_total), 32'd0);

    // Job 2: 20 matches, read latency 3, host ready toggling
    start_job(2'd1, 9'd1);
    load_keys(1, 14'h3ff);
    resp_en = 1'b1;
    rd_idx = 0;
    reads_total = 0;
    @(posedge ICLK); #1;
    MATCH_COUNT = 32'd20;
    MATCH_COUNT_VALID = 1'b1;
    pops = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 1000 && !done_seen; c++) begin
      @(posedge ICLK); #1;
      MATCH_COUNT_VALID = 1'b0;
      RES_READY = (c % 2 == 0);
      @(negedge ICLK);
      if (RES_VALID && RES_READY) begin
        check("j2_data", 32'(RES_DATA), 32'(16'hA000 + 16'(pops)));
        check("j2_last", 32'(RES_LAST), (pops == 19) ? 32'd1 : 32'd0);
        pops++;
      end
      if (DONE) begin
        done_seen = 1'b1;
        check("j2_icontinue", 32'(ICONTINUE), 32'd1);
      end
    end
    RES_READY = 1'b0;
    resp_en = 1'b0;
    check("j2_done_seen", 32'(done_seen), 32'd1);
    check("j2_pops", 32'(pops), 32'd20);
    check("j2_reads", 32'(reads_total), 32'd20);
    check("j2_matches", MATCHES, 32'd20);
    check("j2_no_timeout", 32'(TIMEOUT_ERR), 32'd0);

    // Job 3: match count never arrives; 64 WAIT_CNT cycles then FINISH
    start_job(2'd0, 9'd2);
    load_keys(2, 14'h020);
    wc = 1;
    while (!DONE && wc < 200) begin
      @(posedge ICLK);
      @(negedge ICLK);
      wc++;
    end
    check("j3_done_cycle", 32'(wc), 32'd65);
    check("j3_timeout", 32'(TIMEOUT_ERR), 32'd1);
    check("j3_icontinue", 32'(ICONTINUE), 32'd1);
    @(posedge ICLK); #1;
    @(negedge ICLK);
    check("j3_timeout_sticky", 32'(TIMEOUT_ERR), 32'd1);
    check("j3_idle", 32'(BUSY), 32'd0);

    // Job 4: len 0 behaves as 1; accept clears TIMEOUT_ERR
    start_job(2'd3, 9'd0);
    check("j4_timeout_clr", 32'(TIMEOUT_ERR), 32'd0);
    check("j4_bytemode", 32'(BUFFER_BYTEMODE), 32'd3);
    load_keys(1, 14'h2aa);

    // Reset in the middle of DRAIN
    resp_en = 1'b1;
    rd_idx = 0;
    @(posedge ICLK); #1;
    MATCH_COUNT = 32'd5;
    MATCH_COUNT_VALID = 1'b1;
    @(posedge ICLK); #1;
    MATCH_COUNT_VALID = 1'b0;
    got_res = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ICLK);
      if (RES_VALID) begin
        got_res = 1'b1;
        break;
      end
    end
    check("j4_result_buffered", 32'(got_res), 32'd1);
    IRESET = 1'b1;
    @(negedge ICLK);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_res_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check("mid_rst_matches", MATCHES, 32'd0);
    IRESET = 1'b0;
    resp_en = 1'b0;
    done_cnt = 0;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge ICLK);
      if (DONE) done_cnt++;
      if (RES_VALID) seen_valid = 1'b1;
    end
    check("post_rst_no_done", 32'(done_cnt), 32'd0);
    check("post_rst_no_result", 32'(seen_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
